// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: one data-memory request per accepted access, with a wait-state timeout.
// Optional MISALIGN_TRAP_EN rejects misaligned halfword/word accesses with an error response.
module load_store_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_done,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;

    logic              req_legal;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata_fmt;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic [7:0]        cnt_inc;

    // Incoming request decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        req_legal     = 1'b0;
        req_be        = 4'b1111;
        req_wdata_fmt = req_wdata;
        if (req_we) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
            case (req_funct3)
                3'b000: begin
                    req_be        = 4'b0001 << req_addr[1:0];
                    req_wdata_fmt = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    req_be        = 4'b0011 << {req_addr[1], 1'b0};
                    req_wdata_fmt = {2{req_wdata[15:0]}};
                end
                default: ;
            endcase
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010)
                     || (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
`ifdef MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01) && req_addr[0])
            req_legal = 1'b0;
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
            req_legal = 1'b0;
`endif
    end

    // Load alignment and extension from the returned word.
    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = mem_rdata;
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = 32'd0;
        endcase
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        off_d        = off_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    mem_we_d = req_we;
                    if (req_legal) begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata_fmt;
                        cnt_d       = 8'd0;
                    end else begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc;
                // A ready arriving on the final allowed cycle still completes the access.
                if (mem_ready) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? 32'd0 : ld_data;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'd0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            cnt_q        <= 8'd0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_done  = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed steps plus random accesses against an arithmetic reference model.
module tb_load_store_unit;

    localparam int MEM_TIMEOUT = 16;
    localparam int ADDR_W      = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_done, resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_req, mem_we, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_done(resp_done), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: what a request should produce, from the size/sign rules in plain arithmetic.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mrdata,
                         output logic legal, output logic [3:0] be,
                         output logic [31:0] wd, output logic [31:0] rd);
        int unsigned off;
        int unsigned b;
        int unsigned h;
        off = addr % 4;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef MISALIGN_TRAP_EN
        if ((f3 % 4 == 1) && (off % 2 != 0)) legal = 1'b0;
        if ((f3 % 4 == 2) && (off != 0))     legal = 1'b0;
`endif
        be = 4'd15;
        wd = wdata;
        if (we && f3 == 3'd0) begin
            be = 4'(1 << off);
            wd = (wdata & 32'hFF) * 32'h01010101;
        end else if (we && f3 == 3'd1) begin
            be = 4'(3 << ((off / 2) * 2));
            wd = (wdata & 32'hFFFF) * 32'h00010001;
        end
        b = (mrdata >> (8 * off)) & 32'hFF;
        h = (mrdata >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    rd = (b >= 128) ? b - 256 : b;
            3'd1:    rd = (h >= 32768) ? h - 65536 : h;
            3'd2:    rd = mrdata;
            3'd4:    rd = b;
            3'd5:    rd = h;
            default: rd = 32'd0;
        endcase
        if (we) rd = 32'd0;
    endtask

    // One complete access; delay = ACCESS cycles before mem_ready (>= MEM_TIMEOUT means never).
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mrdata, input int delay);
        logic        legal;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd;
        int          k;
        int          budget;
        model(we, f3, addr, wdata, mrdata, legal, ebe, ewd, erd);
        budget = 0;
        while (req_ready !== 1'b1 && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        req_we     = 1'($urandom);
        check({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
        if (!legal) begin
            check({tag, ".illegal_no_req"}, 32'(mem_req), 32'd0);
            check({tag, ".illegal_done"}, 32'(resp_done), 32'd1);
            check({tag, ".illegal_err"}, 32'(resp_err), 32'd1);
            check({tag, ".illegal_rdata"}, resp_rdata, 32'd0);
        end else begin
            check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
            check({tag, ".mem_we"}, 32'(mem_we), 32'(we));
            check({tag, ".mem_addr"}, mem_addr, addr - (addr % 4));
            check({tag, ".mem_be"}, 32'(mem_be), 32'(ebe));
            if (we) check({tag, ".mem_wdata"}, mem_wdata, ewd);
            k = 0;
            while (mem_req === 1'b1 && k < MEM_TIMEOUT + 4) begin
                if (k > 0) check({tag, ".addr_stable"}, mem_addr, addr - (addr % 4));
                check({tag, ".no_early_done"}, 32'(resp_done), 32'd0);
                mem_ready = (k == delay);
                mem_rdata = (k == delay) ? mrdata : $urandom;
                @(posedge clk); #1;
                k++;
            end
            mem_ready = 1'b0;
            check({tag, ".req_cycles"}, 32'(k), 32'((delay < MEM_TIMEOUT) ? delay + 1 : MEM_TIMEOUT));
            check({tag, ".done"}, 32'(resp_done), 32'd1);
            check({tag, ".err"}, 32'(resp_err), 32'(delay >= MEM_TIMEOUT));
            check({tag, ".rdata"}, resp_rdata, (delay >= MEM_TIMEOUT) ? 32'd0 : erd);
        end
        @(posedge clk); #1;
        check({tag, ".done_one_cycle"}, 32'(resp_done), 32'd0);
        check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = 32'd0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'd0;
        #1;
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_be", 32'(mem_be), 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.resp_done", 32'(resp_done), 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_req("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        run_req("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);
        run_req("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2);
        run_req("sh", 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1);
        run_req("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'hABCD1234, 0);
        run_req("lh_lo", 1'b0, 3'b001, 32'h200, 32'h0, 32'h1234F00D, 3);
        run_req("sb1", 1'b1, 3'b000, 32'h301, 32'h123456A5, 32'h0, 0);
        run_req("lw_timeout", 1'b0, 3'b010, 32'h400, 32'h0, 32'h11111111, MEM_TIMEOUT + 5);
        run_req("lw_last_cycle", 1'b0, 3'b010, 32'h404, 32'h0, 32'hCAFEF00D, MEM_TIMEOUT - 1);
        run_req("illegal_011", 1'b0, 3'b011, 32'h500, 32'h0, 32'h0, 0);
        run_req("illegal_sbu", 1'b1, 3'b100, 32'h504, 32'h0, 32'h0, 0);
        run_req("lw_misalign", 1'b0, 3'b010, 32'h101, 32'h0, 32'h76543210, 0);

        // Abandon an access with an asynchronous reset.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h600;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("arst.mem_req_before", 32'(mem_req), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("arst.mem_req_dropped", 32'(mem_req), 32'd0);
        check("arst.no_done", 32'(resp_done), 32'd0);
        check("arst.ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst.no_done_after", 32'(resp_done), 32'd0);
        run_req("post_rst", 1'b0, 3'b000, 32'h602, 32'h0, 32'h00C30000, 1);

        // A stray mem_ready while idle must not produce anything.
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        repeat (2) begin
            @(posedge clk); #1;
            check("idle_ready.no_done", 32'(resp_done), 32'd0);
            check("idle_ready.no_req", 32'(mem_req), 32'd0);
        end
        mem_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            run_req("rand", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, MEM_TIMEOUT + 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
